// File: rtl/hazard_ctrl_pkg.sv
// Shared state encodings and sizing helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d;

   // next count: clear, else step unless already all-ones
   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (inc && !(&q_q))
         q_d = q_q + 1'b1;
   end

   // count register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) q_q <= '0;
      else         q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for IF/ID, ID/EX and PC: load-use bubbles, taken-branch
// flushes and a full freeze while data memory is busy, plus debug counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int CNT_W       = 16,
   parameter int LOAD_STALLS = 1,
   parameter int BR_PENALTY  = 1
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [ADDR_W-1:0]  id_rs,
   input  logic [ADDR_W-1:0]  id_rt,
   input  logic               id_rs_used,
   input  logic               id_rt_used,
   input  logic [ADDR_W-1:0]  ex_rd,
   input  logic               ex_mem_read,
   input  logic               ex_br_taken,
   input  logic               mem_busy,
   input  logic               cnt_clr,
   output logic               pc_we,
   output logic               ifid_we,
   output logic               ifid_flush,
   output logic               idex_we,
   output logic               idex_flush,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);
   localparam int REM_MAX = max2(LOAD_STALLS, BR_PENALTY);
   localparam int REM_W   = $clog2(REM_MAX + 1);
   localparam logic [REM_W-1:0] LS_INIT = REM_W'(LOAD_STALLS - 1);
   localparam logic [REM_W-1:0] BP_INIT = REM_W'(BR_PENALTY - 1);
   localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

   state_e           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic             pc_we_c, ifid_we_c, ifid_flush_c, idex_we_c, idex_flush_c;
   logic             flush_evt;
   logic             hazard;

   // r0 is hardwired, so a load targeting it never forms a dependency
   function automatic logic load_use(
      input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
      input logic rs_used, input logic rt_used,
      input logic [ADDR_W-1:0] rd, input logic mem_read);
      return mem_read && (rd != '0) &&
             ((rs_used && (rs == rd)) || (rt_used && (rt == rd)));
   endfunction

   assign hazard = load_use(id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read);

   // enables, flushes and next state; mem_busy > branch > hazard everywhere
   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      pc_we_c      = 1'b0;
      ifid_we_c    = 1'b0;
      ifid_flush_c = 1'b0;
      idex_we_c    = 1'b0;
      idex_flush_c = 1'b0;
      flush_evt    = 1'b0;
      if (mem_busy) begin
         // whole pipe frozen; a stall/flush in progress simply resumes later
         if (state_q == ST_RUN) state_d = ST_MEM_WAIT;
      end else begin
         case (state_q)
            ST_MEM_WAIT: state_d = ST_RUN;
            ST_FLUSH: begin
               {pc_we_c, ifid_we_c, idex_we_c} = 3'b111;
               {ifid_flush_c, idex_flush_c}    = 2'b11;
               rem_d = rem_q - 1'b1;
               if (rem_q == REM_ONE) state_d = ST_RUN;
            end
            ST_LOAD_STALL: begin
               idex_we_c    = 1'b1;
               idex_flush_c = 1'b1;
               rem_d = rem_q - 1'b1;
               if (rem_q == REM_ONE) state_d = ST_RUN;
            end
            default: begin
               if (ex_br_taken) begin
                  {pc_we_c, ifid_we_c, idex_we_c} = 3'b111;
                  {ifid_flush_c, idex_flush_c}    = 2'b11;
                  flush_evt = 1'b1;
                  if (BR_PENALTY > 1) begin
                     rem_d   = BP_INIT;
                     state_d = ST_FLUSH;
                  end
               end else if (hazard) begin
                  idex_we_c    = 1'b1;
                  idex_flush_c = 1'b1;
                  if (LOAD_STALLS > 1) begin
                     rem_d   = LS_INIT;
                     state_d = ST_LOAD_STALL;
                  end
               end else begin
                  {pc_we_c, ifid_we_c, idex_we_c} = 3'b111;
               end
            end
         endcase
      end
   end

   // state and bubble/flush down-counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RUN;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   assign pc_we      = resetn & pc_we_c;
   assign ifid_we    = resetn & ifid_we_c;
   assign ifid_flush = resetn & ifid_flush_c;
   assign idex_we    = resetn & idex_we_c;
   assign idex_flush = resetn & idex_flush_c;
   assign state      = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clock(clock), .resetn(resetn), .clr(cnt_clr), .inc(~pc_we), .q(stall_cnt));

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clock(clock), .resetn(resetn), .clr(cnt_clr), .inc(flush_evt), .q(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl built with 3 load bubbles, 2 flush cycles, 4-bit counters.
module tb_hazard_ctrl;
   localparam int AW = 6, CW = 4, LS = 3, BP = 2, CMAX = 15;

   logic          clock, resetn;
   logic [AW-1:0] id_rs, id_rt, ex_rd;
   logic          id_rs_used, id_rt_used, ex_mem_read, ex_br_taken, mem_busy, cnt_clr;
   logic          pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
   logic [1:0]    state;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.ADDR_W(AW), .CNT_W(CW), .LOAD_STALLS(LS), .BR_PENALTY(BP)) dut (
      .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
      .cnt_clr(cnt_clr), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_flush(idex_flush), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errs = 0, checks = 0;

   // reference: remaining bubble/flush cycles, memory-wait flag, counter values
   int m_ps, m_pf, m_sc, m_fc;
   bit m_mw;
   int c_pc, c_ifwe, c_iff, c_idwe, c_idf;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int mstate();
      if (m_mw)       return 3;
      if (m_pf > 0)   return 2;
      if (m_ps > 0)   return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_ps = 0; m_pf = 0; m_sc = 0; m_fc = 0; m_mw = 0;
   endtask

   // one clock: apply inputs, check combinational outputs, advance model, check registers
   task automatic step(input bit mb, input bit br, input bit mr, input bit rsu,
                       input bit rtu, input bit clr, input int rs, input int rt, input int rd);
      int e_pc, e_ifwe, e_iff, e_idwe, e_idf;
      bit hz, inc_f;
      mem_busy = mb; ex_br_taken = br; ex_mem_read = mr; id_rs_used = rsu;
      id_rt_used = rtu; cnt_clr = clr; id_rs = 6'(rs); id_rt = 6'(rt); ex_rd = 6'(rd);
      #1;
      hz = mr && (rd != 0) && ((rsu && rs == rd) || (rtu && rt == rd));
      {e_pc, e_ifwe, e_iff, e_idwe, e_idf} = {5{32'd0}};
      inc_f = 0;
      if (mb || m_mw) ;
      else if (m_pf > 0)     begin e_pc = 1; e_ifwe = 1; e_iff = 1; e_idwe = 1; e_idf = 1; end
      else if (m_ps > 0)     begin e_idwe = 1; e_idf = 1; end
      else if (br)           begin e_pc = 1; e_ifwe = 1; e_iff = 1; e_idwe = 1; e_idf = 1; inc_f = 1; end
      else if (hz)           begin e_idwe = 1; e_idf = 1; end
      else                   begin e_pc = 1; e_ifwe = 1; e_idwe = 1; end
      c_pc = int'(pc_we); c_ifwe = int'(ifid_we); c_iff = int'(ifid_flush);
      c_idwe = int'(idex_we); c_idf = int'(idex_flush);
      chk("pc_we", c_pc, e_pc);
      chk("ifid_we", c_ifwe, e_ifwe);
      chk("ifid_flush", c_iff, e_iff);
      chk("idex_we", c_idwe, e_idwe);
      chk("idex_flush", c_idf, e_idf);
      chk("state_pre", int'(state), mstate());
      if (m_mw) begin
         if (!mb) m_mw = 0;
      end else if (mb && m_pf == 0 && m_ps == 0) m_mw = 1;
      if (!(mb || (m_mw && !mb && 0))) begin end
      if (!mb && mstate() != 3 && e_pc + e_idwe > 0) begin
         if (m_pf > 0)      m_pf--;
         else if (m_ps > 0) m_ps--;
         else if (br)       m_pf = BP - 1;
         else if (hz)       m_ps = LS - 1;
      end
      if (clr) begin m_sc = 0; m_fc = 0; end
      else begin
         if (e_pc == 0 && m_sc < CMAX) m_sc++;
         if (inc_f && m_fc < CMAX)     m_fc++;
      end
      @(posedge clock); #1;
      chk("stall_cnt", int'(stall_cnt), m_sc);
      chk("flush_cnt", int'(flush_cnt), m_fc);
      chk("state", int'(state), mstate());
   endtask

   task automatic nop();      step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic clr_step(); step(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
   task automatic ld_use();   step(0, 0, 1, 1, 0, 0, 5, 0, 5); endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      resetn = 0; mem_busy = 0; ex_br_taken = 0; ex_mem_read = 0; id_rs_used = 0;
      id_rt_used = 0; cnt_clr = 0; id_rs = '0; id_rt = '0; ex_rd = '0;
      #2;
      chk("rst_pc_we", int'(pc_we), 0);
      chk("rst_idex_we", int'(idex_we), 0);
      repeat (2) @(posedge clock);
      #3 resetn = 1;
      @(posedge clock); #1;
      chk("rst_state", int'(state), 0);
      chk("rst_stall_cnt", int'(stall_cnt), 0);

      // no hazard
      repeat (10) step(0, 0, 0, 1, 1, 0, $urandom_range(0, 63), $urandom_range(0, 63), 0);
      chk("nohaz_stall_cnt", int'(stall_cnt), 0);

      // load-use: three bubbles, then the pipe runs again
      ld_use();
      chk("lu_pc_we", c_pc, 0);
      chk("lu_idex_flush", c_idf, 1);
      chk("lu_state", int'(state), 1);
      ld_use(); ld_use();
      chk("lu_done_state", int'(state), 0);
      chk("lu_stall_cnt", int'(stall_cnt), 3);
      nop();
      chk("lu_resume_pc_we", c_pc, 1);
      step(0, 0, 1, 1, 1, 0, 0, 0, 0);
      chk("r0_pc_we", c_pc, 1);
      chk("r0_stall_cnt", int'(stall_cnt), 3);

      // branch beats hazard in the same cycle
      clr_step();
      step(0, 1, 1, 1, 0, 0, 5, 0, 5);
      chk("br_ifid_flush", c_iff, 1);
      chk("br_idex_flush", c_idf, 1);
      chk("br_pc_we", c_pc, 1);
      chk("br_flush_cnt", int'(flush_cnt), 1);
      chk("br_stall_cnt", int'(stall_cnt), 0);
      chk("br_state", int'(state), 2);
      step(0, 1, 1, 1, 0, 0, 5, 0, 5);
      chk("fl_ifid_flush", c_iff, 1);
      chk("fl_flush_cnt", int'(flush_cnt), 1);
      chk("fl_state", int'(state), 0);

      // memory busy for 3 cycles, released through MEM_WAIT
      clr_step();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mb_pc_we", c_pc, 0);
      chk("mb_state", int'(state), 3);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mb_stall3", int'(stall_cnt), 3);
      nop();
      chk("mw_pc_we", c_pc, 0);
      chk("mw_exit_state", int'(state), 0);
      chk("mw_stall_cnt", int'(stall_cnt), 4);
      nop();
      chk("mw_run_pc_we", c_pc, 1);

      // busy during LOAD_STALL stretches it by exactly the busy length
      clr_step();
      ld_use();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lsmb_state", int'(state), 1);
      nop();
      chk("lsmb_idex_flush", c_idf, 1);
      nop();
      nop();
      chk("lsmb_run_pc_we", c_pc, 1);
      chk("lsmb_stall_cnt", int'(stall_cnt), 5);

      // saturation and clear
      repeat (20) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sat_stall_cnt", int'(stall_cnt), 15);
      clr_step();
      chk("clr_stall_cnt", int'(stall_cnt), 0);

      // reset in the middle of a flush
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_state", int'(state), 2);
      ex_br_taken = 0;
      #2 resetn = 0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_pc_we", int'(pc_we), 0);
      chk("arst_ifid_flush", int'(ifid_flush), 0);
      chk("arst_idex_flush", int'(idex_flush), 0);
      chk("arst_flush_cnt", int'(flush_cnt), 0);
      model_reset();
      @(posedge clock);
      #3 resetn = 1;
      @(posedge clock); #1;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 45, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 99) < 3, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
